// File: rtl/seq_det_param_fsm.sv
// -----------------------------------------------------------------------------
// seq_det_param_fsm
//
// Purpose:
//   Serial pattern detector with a run-time loadable PAT_LEN-bit pattern.
//   Bits are accepted only while in_valid is high. A registered (Moore)
//   detector_out pulses for one cycle after the bit that completes a match.
//   Overlapping or non-overlapping detection is selected per match by
//   overlap_en. Matches are counted in a saturating counter with a
//   synchronous clear.
//
// Ports:
//   clock         in   1        single clock, rising edge
//   reset         in   1        asynchronous, active-high reset
//   sequence_in   in   1        serial data bit
//   in_valid      in   1        qualifies sequence_in
//   pattern_in    in   PAT_LEN  new pattern, bit PAT_LEN-1 is received first
//   load_pattern  in   1        one-cycle strobe latching pattern_in
//   overlap_en    in   1        1 = overlapping, 0 = non-overlapping detection
//   count_clr     in   1        synchronous clear of match_count
//   detector_out  out  1        high for one cycle after a match
//   match_count   out  CNT_W    saturating number of matches
// -----------------------------------------------------------------------------
module seq_det_param_fsm #(
    parameter int                 PAT_LEN     = 4,
    parameter int                 CNT_W       = 8,
    parameter logic [PAT_LEN-1:0] DEF_PATTERN = PAT_LEN'(4'b1011)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sequence_in,
    input  logic               in_valid,
    input  logic [PAT_LEN-1:0] pattern_in,
    input  logic               load_pattern,
    input  logic               overlap_en,
    input  logic               count_clr,
    output logic               detector_out,
    output logic [CNT_W-1:0]   match_count
);

    localparam int                FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ARMED = 2'd1,
        ST_MATCH = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PAT_LEN-1:0] pat_q,   pat_d;
    logic [PAT_LEN-1:0] win_q,   win_d;
    logic [FILL_W-1:0]  fill_q,  fill_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [PAT_LEN-1:0] win_shift;
    logic [FILL_W-1:0]  fill_next;
    logic               match;

    // Fill level saturates at PAT_LEN: once the window is full it stays full.
    function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] f);
        return (f == FILL_FULL) ? f : f + FILL_W'(1);
    endfunction

    // Match counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Window as it would look after accepting sequence_in (oldest bit drops out).
    assign win_shift = (win_q << 1) | {{(PAT_LEN-1){1'b0}}, sequence_in};
    assign fill_next = fill_inc(fill_q);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_FILL;
            pat_q   <= DEF_PATTERN;
            win_q   <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            win_q   <= win_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        win_d   = win_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        match   = 1'b0;

        if (load_pattern) begin
            // A new pattern restarts detection; a bit offered in the same
            // cycle is dropped so the new pattern needs PAT_LEN fresh bits.
            pat_d   = pattern_in;
            win_d   = '0;
            fill_d  = '0;
            state_d = ST_FILL;
        end else begin
            if (in_valid) begin
                win_d  = win_shift;
                fill_d = fill_next;
                match  = (win_shift == pat_q) && (fill_next == FILL_FULL);
            end

            if (match) begin
                state_d = ST_MATCH;
                // Non-overlapping mode forgets the matched bits entirely.
                fill_d  = overlap_en ? FILL_FULL : '0;
            end else begin
                // FILL/ARMED follow directly from the fill level, which also
                // gives the one-cycle MATCH exit whether or not a bit arrives.
                state_d = (fill_d == FILL_FULL) ? ST_ARMED : ST_FILL;
            end
        end

        // Clear wins over a coincident match.
        if (count_clr) begin
            cnt_d = '0;
        end else if (match) begin
            cnt_d = cnt_inc(cnt_q);
        end
    end

    assign detector_out = (state_q == ST_MATCH);
    assign match_count  = cnt_q;

endmodule

// File: tb/tb_seq_det_param_fsm.sv
// -----------------------------------------------------------------------------
// tb_seq_det_param_fsm
//
// Purpose:
//   Directed self-checking bench for seq_det_param_fsm (PAT_LEN=4, CNT_W=2 so
//   counter saturation is reachable in a few matches).
// -----------------------------------------------------------------------------
module tb_seq_det_param_fsm;

    localparam int PAT_LEN = 4;
    localparam int CNT_W   = 2;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               sequence_in = 1'b0;
    logic               in_valid = 1'b0;
    logic [PAT_LEN-1:0] pattern_in = '0;
    logic               load_pattern = 1'b0;
    logic               overlap_en = 1'b0;
    logic               count_clr = 1'b0;
    logic               detector_out;
    logic [CNT_W-1:0]   match_count;

    int n_chk  = 0;
    int n_fail = 0;

    seq_det_param_fsm #(
        .PAT_LEN    (PAT_LEN),
        .CNT_W      (CNT_W),
        .DEF_PATTERN(4'b1011)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sequence_in (sequence_in),
        .in_valid    (in_valid),
        .pattern_in  (pattern_in),
        .load_pattern(load_pattern),
        .overlap_en  (overlap_en),
        .count_clr   (count_clr),
        .detector_out(detector_out),
        .match_count (match_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one bit for one clock; outputs are sampled 1 time unit after the edge.
    task automatic send(input logic b, input logic v);
        @(negedge clock);
        sequence_in = b;
        in_valid    = v;
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        count_clr = 1'b0;
    endtask

    // Reset held over `cycles` rising edges with outputs checked each cycle.
    task automatic do_reset(input int cycles, input string tag);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
            chk({tag, "_det"}, 32'(detector_out), 32'd0);
            chk({tag, "_cnt"}, 32'(match_count), 32'd0);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Send n valid bits (MSB of the n-bit field first) checking detector_out after each.
    task automatic run_bits(input logic [15:0] bits, input logic [15:0] exp_det,
                            input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            send(bits[n-1-i], 1'b1);
            chk($sformatf("%s_b%0d", tag, i + 1), 32'(detector_out), 32'(exp_det[n-1-i]));
        end
    endtask

    initial begin
        // Reset for 3 cycles, default pattern loaded.
        do_reset(3, "rst");
        @(posedge clock);
        #1;
        chk("rst_pat", 32'(dut.pat_q), 32'hB);
        chk("rst_det_after", 32'(detector_out), 32'd0);
        chk("rst_cnt_after", 32'(match_count), 32'd0);

        // Overlapping: 1011011 -> pulses after bits 4 and 7.
        overlap_en = 1'b1;
        run_bits(16'b1011011, 16'b0001001, 7, "ovl");
        chk("ovl_cnt", 32'(match_count), 32'd2);
        send(1'b0, 1'b0);
        chk("ovl_exit", 32'(detector_out), 32'd0);

        // Non-overlapping: same stream -> single pulse after bit 4.
        do_reset(1, "r2");
        overlap_en = 1'b0;
        run_bits(16'b1011011, 16'b0001000, 7, "novl");
        chk("novl_cnt", 32'(match_count), 32'd1);

        // Gaps in in_valid do not break the sequence.
        do_reset(1, "r3");
        run_bits(16'b10, 16'b00, 2, "gap_a");
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 1'b0);
            chk($sformatf("gap_idle%0d", i), 32'(detector_out), 32'd0);
        end
        run_bits(16'b11, 16'b01, 2, "gap_b");
        chk("gap_cnt", 32'(match_count), 32'd1);

        // Counter saturation with CNT_W=2, then clear coinciding with a match.
        do_reset(1, "r4");
        overlap_en = 1'b1;
        run_bits(16'b1011, 16'b0001, 4, "sat1");
        chk("sat_cnt1", 32'(match_count), 32'd1);
        for (int k = 2; k <= 5; k++) begin
            run_bits(16'b011, 16'b001, 3, $sformatf("sat%0d", k));
            chk($sformatf("sat_cnt%0d", k), 32'(match_count), 32'((k > 3) ? 3 : k));
        end
        run_bits(16'b01, 16'b00, 2, "sat6");
        @(negedge clock);
        count_clr = 1'b1;
        send(1'b1, 1'b1);
        chk("clr_det", 32'(detector_out), 32'd1);
        chk("clr_cnt", 32'(match_count), 32'd0);

        // Reset mid-sequence discards progress; then load a new pattern.
        do_reset(1, "r5");
        overlap_en = 1'b0;
        run_bits(16'b101, 16'b000, 3, "mid");
        do_reset(1, "r6");
        run_bits(16'b1, 16'b0, 1, "post_rst");
        @(negedge clock);
        load_pattern = 1'b1;
        pattern_in   = 4'b0110;
        sequence_in  = 1'b0;
        in_valid     = 1'b1;
        @(posedge clock);
        #1;
        load_pattern = 1'b0;
        in_valid     = 1'b0;
        chk("load_pat", 32'(dut.pat_q), 32'h6);
        chk("load_det", 32'(detector_out), 32'd0);
        run_bits(16'b0110, 16'b0001, 4, "newpat");
        chk("newpat_cnt", 32'(match_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_det_param_fsm.md
SEQ_DET_PARAM_FSM -- requirements
Module: seq_det_param_fsm

Interface
REQ-001 SHALL have parameter PAT_LEN, default 4, giving the pattern length in bits (legal range 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, giving the match counter width.
REQ-003 SHALL have parameter DEF_PATTERN, default 4'b1011 (PAT_LEN bits), giving the pattern loaded at reset.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port sequence_in, input, 1 bit: serial data bit.
REQ-007 SHALL have port in_valid, input, 1 bit: sequence_in is sampled only when in_valid=1.
REQ-008 SHALL have port pattern_in, input, PAT_LEN bits: new pattern; bit PAT_LEN-1 is the first bit received.
REQ-009 SHALL have port load_pattern, input, 1 bit: one-cycle strobe that latches pattern_in.
REQ-010 SHALL have port overlap_en, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping.
REQ-011 SHALL have port count_clr, input, 1 bit: synchronous clear of match_count.
REQ-012 SHALL have port detector_out, output, 1 bit: Moore match output.
REQ-013 SHALL have port match_count, output, CNT_W bits: saturating count of matches.

Function
REQ-014 SHALL hold internal registers pat_reg (PAT_LEN), window (PAT_LEN, new bit shifted into LSB), fill (0..PAT_LEN) and state.
REQ-015 SHALL implement states FILL (fill<PAT_LEN), ARMED (fill==PAT_LEN, no match), MATCH (last accepted bit completed a match).
REQ-016 SHALL drive detector_out high only when state==MATCH, decoded from the state register with no combinational path from the inputs.
REQ-017 SHALL, on each accepted bit, shift window left, insert sequence_in at the LSB, and increment fill, saturating at PAT_LEN.
REQ-018 SHALL detect a match when the post-shift window equals pat_reg and the post-shift fill equals PAT_LEN; state becomes MATCH at that edge, so detector_out is high in the following cycle.
REQ-019 SHALL leave MATCH after exactly one cycle: to ARMED (overlap) or FILL (non-overlap), unless that cycle's accepted bit completes another match.
REQ-020 SHALL, when a match occurs with overlap_en=0, set fill to 0 so that the next match requires PAT_LEN fresh bits.
REQ-021 SHALL, when overlap_en=1, keep fill at PAT_LEN after a match so that consecutive matches may share bits.
REQ-022 SHALL hold window, fill and state (except the MATCH exit) while in_valid=0; gaps do not break a sequence.
REQ-023 SHALL, on load_pattern=1, set pat_reg to pattern_in, fill to 0 and state to FILL, and discard any bit sampled in the same cycle.
REQ-024 SHALL increment match_count by 1 per match, saturating at 2^CNT_W-1 with no wrap.
REQ-025 SHALL give count_clr priority: when count_clr coincides with a match, match_count becomes 0 and that match is not counted, while detector_out still asserts.
REQ-026 SHALL sample overlap_en at the match edge; changing it mid-stream has no other effect.

Reset
REQ-027 SHALL, while reset=1, asynchronously force pat_reg=DEF_PATTERN, window=0, fill=0, state=FILL, detector_out=0 and match_count=0.
REQ-028 SHALL, when reset asserts mid-sequence, discard all partial progress; after release a full PAT_LEN-bit match is required.

Verification
REQ-029 SHALL be verified as follows: assert reset for 3 cycles, then release -> detector_out=0 and match_count=0 throughout, and pat_reg=1011.
REQ-030 SHALL be verified as follows: with overlap_en=1, drive valid bits 1,0,1,1,0,1,1 -> detector_out pulses one cycle after bits 4 and 7, and match_count=2.
REQ-031 SHALL be verified as follows: with overlap_en=0 and the same stream -> a single pulse after bit 4 and match_count=1.
REQ-032 SHALL be verified as follows: drive 1,0, then in_valid=0 for 3 cycles, then 1,1 -> one pulse one cycle after the final bit.
REQ-033 SHALL be verified as follows: with CNT_W=2, produce 5 matches -> match_count reads 1,2,3,3,3; then count_clr together with a 6th match -> count=0 and detector_out=1.
REQ-034 SHALL be verified as follows: drive 1,0,1, pulse reset, then drive 1 -> no pulse; then load_pattern with pattern_in=4'b0110 and drive 0,1,1,0 -> one pulse.
